wb_stage_skid_reg: RTL and testbench



---
 rtl/wb_stage_skid_reg.sv | 127 ++++++++++++
 tb/tb_wb_stage_skid_reg.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_skid_reg.sv
// Write-back stage register with one skid slot: a two-entry FIFO where in_ready
// depends only on registered occupancy. It also counts downstream stall cycles.
module wb_stage_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RN_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_mo,
    input  logic [RN_W-1:0]   mem_rn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_wreg,
    output logic              wb_m2reg,
    output logic [DATA_W-1:0] wb_alu,
    output logic [DATA_W-1:0] wb_mo,
    output logic [RN_W-1:0]   wb_rn,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mo;
        logic [RN_W-1:0]   rn;
    } ent_t;

    ent_t             in_ent;
    ent_t             out_q, out_d;
    ent_t             skid_q, skid_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept;
    logic             pop;

    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != CNT_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        in_ent.wreg  = mem_wreg;
        in_ent.m2reg = mem_m2reg;
        in_ent.alu   = mem_alu;
        in_ent.mo    = mem_mo;
        in_ent.rn    = mem_rn;
    end

    always_comb begin
        out_d   = out_q;
        skid_d  = skid_q;
        count_d = count_q;
        if (flush) begin
            // Only occupancy is cleared; held data fields stay as they were.
            count_d = CNT_EMPTY;
        end else begin
            case (count_q)
                CNT_EMPTY: begin
                    if (accept) begin
                        out_d   = in_ent;
                        count_d = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (accept && pop) begin
                        out_d = in_ent;
                    end else if (accept) begin
                        skid_d  = in_ent;
                        count_d = CNT_FULL;
                    end else if (pop) begin
                        count_d = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (pop) begin
                        out_d   = skid_q;
                        count_d = CNT_ONE;
                    end
                end
                default: count_d = CNT_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            out_q   <= '0;
            skid_q  <= '0;
            count_q <= CNT_EMPTY;
            stall_q <= '0;
        end else begin
            out_q   <= out_d;
            skid_q  <= skid_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    assign wb_wreg   = out_valid & out_q.wreg;
    assign wb_m2reg  = out_q.m2reg;
    assign wb_alu    = out_q.alu;
    assign wb_mo     = out_q.mo;
    assign wb_rn     = out_q.rn;
    assign wb_data   = out_q.m2reg ? out_q.mo : out_q.alu;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// Bench for wb_stage_skid_reg: a queue scoreboard is updated at each rising edge
// from the driven inputs and compared against the outputs on the falling edge.
module tb_wb_stage_skid_reg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned RN_W      = 5;
    localparam int unsigned CNT_W     = 4;
    localparam int          STALL_MAX = 15;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mo;
        logic [RN_W-1:0]   rn;
    } ent_t;

    logic              clk = 1'b0;
    logic              clr;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              mem_wreg;
    logic              mem_m2reg;
    logic [DATA_W-1:0] mem_alu;
    logic [DATA_W-1:0] mem_mo;
    logic [RN_W-1:0]   mem_rn;
    logic              out_valid;
    logic              out_ready;
    logic              wb_wreg;
    logic              wb_m2reg;
    logic [DATA_W-1:0] wb_alu;
    logic [DATA_W-1:0] wb_mo;
    logic [RN_W-1:0]   wb_rn;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  stall_cnt;

    wb_stage_skid_reg #(
        .DATA_W (DATA_W),
        .RN_W   (RN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_wreg  (mem_wreg),
        .mem_m2reg (mem_m2reg),
        .mem_alu   (mem_alu),
        .mem_mo    (mem_mo),
        .mem_rn    (mem_rn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_wreg   (wb_wreg),
        .wb_m2reg  (wb_m2reg),
        .wb_alu    (wb_alu),
        .wb_mo     (wb_mo),
        .wb_rn     (wb_rn),
        .wb_data   (wb_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    ent_t sb_q[$];
    ent_t last_out;
    int   stall_m;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic m,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] mo,
                         input logic [RN_W-1:0] rn);
        in_valid  = v;
        mem_wreg  = w;
        mem_m2reg = m;
        mem_alu   = a;
        mem_mo    = mo;
        mem_rn    = rn;
    endtask

    // Check outputs against the scoreboard, then advance the model across one edge.
    task automatic step();
        ent_t e;
        logic mval;
        logic mrdy;
        ent_t ie;
        @(negedge clk);
        e = (sb_q.size() != 0) ? sb_q[0] : last_out;
        check_eq("in_ready",  64'(in_ready),  64'(sb_q.size() != 2));
        check_eq("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        check_eq("wb_wreg",   64'(wb_wreg),   64'((sb_q.size() != 0) && e.wreg));
        check_eq("wb_m2reg",  64'(wb_m2reg),  64'(e.m2reg));
        check_eq("wb_alu",    64'(wb_alu),    64'(e.alu));
        check_eq("wb_mo",     64'(wb_mo),     64'(e.mo));
        check_eq("wb_rn",     64'(wb_rn),     64'(e.rn));
        check_eq("wb_data",   64'(wb_data),   64'(e.m2reg ? e.mo : e.alu));
        check_eq("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        @(posedge clk);
        mval = (sb_q.size() != 0);
        mrdy = (sb_q.size() != 2);
        ie.wreg  = mem_wreg;
        ie.m2reg = mem_m2reg;
        ie.alu   = mem_alu;
        ie.mo    = mem_mo;
        ie.rn    = mem_rn;
        if (clr) begin
            sb_q.delete();
            last_out = '0;
            stall_m  = 0;
        end else begin
            if (mval && !out_ready && stall_m != STALL_MAX) stall_m++;
            if (flush) begin
                sb_q.delete();
            end else begin
                if (mval && out_ready) void'(sb_q.pop_front());
                if (in_valid && mrdy) sb_q.push_back(ie);
            end
            if (sb_q.size() != 0) last_out = sb_q[0];
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clr = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        last_out = '0;
        stall_m  = 0;
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Reset state
        step();

        // Single write-back entry
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle(3);

        // Fill both slots while stalled; C must be refused
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hA, 32'h1, 5'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'hB, 32'h2, 5'd2);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h3, 5'd4);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        idle(4);

        // Load vs ALU result selection
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'hDEAD, 5'd7);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'hDEAD, 5'd8);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle(2);

        // Flush while full, with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h51, 32'h0, 5'd9);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h52, 32'h0, 5'd10);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h53, 32'h0, 5'd11);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        idle(3);

        // Stall counter saturation and clear
        clr = 1'b1;
        step();
        clr = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, 5'd12);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle(20);
        check_eq("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("stall_clr", 64'(stall_cnt), 64'd0);
        step();

        // Reset mid-operation with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h71, 32'h0, 5'd13);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h72, 32'h0, 5'd14);
        step();
        clr = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h73, 32'h0, 5'd15);
        step();
        clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        idle(3);

        // Back-to-back streaming of 100 entries
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, RN_W'(i));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle(3);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, RN_W'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
